// File: rtl/pipeline_ctrl_if.sv
// Hazard-unit signal bundle: the datapath side is the master, pipeline_ctrl is the slave.
// Carries register indices and write/load flags in, stall/flush/forward controls and counters out.
interface pipeline_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_WIDTH  = 32
);
    logic [REG_ADDR_W-1:0] Rs1D_i;
    logic [REG_ADDR_W-1:0] Rs2D_i;
    logic                  UsesRs1D_i;
    logic                  UsesRs2D_i;
    logic [REG_ADDR_W-1:0] Rs1E_i;
    logic [REG_ADDR_W-1:0] Rs2E_i;
    logic [REG_ADDR_W-1:0] RdE_i;
    logic                  RegWriteE_i;
    logic                  LoadE_i;
    logic [REG_ADDR_W-1:0] RdM_i;
    logic                  RegWriteM_i;
    logic                  LoadM_i;
    logic [REG_ADDR_W-1:0] RdW_i;
    logic                  RegWriteW_i;
    logic                  PCSrcE_i;

    logic                  StallF_o;
    logic                  StallD_o;
    logic                  StallE_o;
    logic                  StallM_o;
    logic                  FlushD_o;
    logic                  FlushE_o;
    logic                  FlushW_o;
    logic [1:0]            ForwardAE_o;
    logic [1:0]            ForwardBE_o;
    logic                  MemWait_o;
    logic [CNT_WIDTH-1:0]  CycleCnt_o;
    logic [CNT_WIDTH-1:0]  StallCnt_o;
    logic [CNT_WIDTH-1:0]  FlushCnt_o;
    logic [CNT_WIDTH-1:0]  RetireCnt_o;

    modport master (
        output Rs1D_i, Rs2D_i, UsesRs1D_i, UsesRs2D_i,
        output Rs1E_i, Rs2E_i, RdE_i, RegWriteE_i, LoadE_i,
        output RdM_i, RegWriteM_i, LoadM_i,
        output RdW_i, RegWriteW_i, PCSrcE_i,
        input  StallF_o, StallD_o, StallE_o, StallM_o,
        input  FlushD_o, FlushE_o, FlushW_o,
        input  ForwardAE_o, ForwardBE_o, MemWait_o,
        input  CycleCnt_o, StallCnt_o, FlushCnt_o, RetireCnt_o
    );

    modport slave (
        input  Rs1D_i, Rs2D_i, UsesRs1D_i, UsesRs2D_i,
        input  Rs1E_i, Rs2E_i, RdE_i, RegWriteE_i, LoadE_i,
        input  RdM_i, RegWriteM_i, LoadM_i,
        input  RdW_i, RegWriteW_i, PCSrcE_i,
        output StallF_o, StallD_o, StallE_o, StallM_o,
        output FlushD_o, FlushE_o, FlushW_o,
        output ForwardAE_o, ForwardBE_o, MemWait_o,
        output CycleCnt_o, StallCnt_o, FlushCnt_o, RetireCnt_o
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard, forwarding and stall sequencer for the 5-stage RV32 pipeline, with a
// multi-cycle load wait FSM, per-stage valid tracking and saturating performance counters.
module pipeline_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_WIDTH  = 32
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.slave hz
);

    localparam int WCNT_W = ($clog2(LOAD_LAT) > 4) ? $clog2(LOAD_LAT) : 4;
    localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'((LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                mw;
    logic                lu;

    logic                stall_f, stall_d, stall_e, stall_m;
    logic                flush_d, flush_e, flush_w;
    logic [1:0]          fwd_a, fwd_b;

    logic                vd_q, vd_d, ve_q, ve_d, vm_q, vm_d, vw_q, vw_d;
    logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_WIDTH-1:0] retire_cnt_q, retire_cnt_d;

    // M beats W so the youngest producer wins; a load in M has no data yet.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rd_m,
        input logic                  we_m,
        input logic                  ld_m,
        input logic [REG_ADDR_W-1:0] rd_w,
        input logic                  we_w
    );
        if (we_m && !ld_m && (rd_m != '0) && (rd_m == rs)) return 2'b10;
        if (we_w && (rd_w != '0) && (rd_w == rs))           return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] c,
        input logic                 en
    );
        return (en && (c != '1)) ? (c + CNT_WIDTH'(1)) : c;
    endfunction

    assign lu = hz.LoadE_i && hz.RegWriteE_i && (hz.RdE_i != '0) &&
                ((hz.UsesRs1D_i && (hz.Rs1D_i == hz.RdE_i)) ||
                 (hz.UsesRs2D_i && (hz.Rs2D_i == hz.RdE_i)));

    // The wait counter only ever holds cycles still to go after the current one.
    always_comb begin : wait_fsm_next
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        wcnt_d  = wcnt_q;
        mw      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (hz.LoadM_i && (LOAD_LAT > 1)) begin
                    mw      = 1'b1;
                    wcnt_d  = WAIT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wcnt_q != '0) begin
                    mw     = 1'b1;
                    wcnt_d = wcnt_q - WCNT_W'(1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin : hazard_comb
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        fwd_a   = 2'b00;
        fwd_b   = 2'b00;
        if (!rst) begin
            fwd_a = fwd_sel(hz.Rs1E_i, hz.RdM_i, hz.RegWriteM_i, hz.LoadM_i, hz.RdW_i, hz.RegWriteW_i);
            fwd_b = fwd_sel(hz.Rs2E_i, hz.RdM_i, hz.RegWriteM_i, hz.LoadM_i, hz.RdW_i, hz.RegWriteW_i);
            // A pending redirect stays in E during a load wait and is taken once it ends.
            if (mw) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else if (hz.PCSrcE_i) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (lu) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    always_comb begin : track_next
        vd_d = flush_d ? 1'b0 : (stall_d ? vd_q : 1'b1);
        ve_d = flush_e ? 1'b0 : (stall_e ? ve_q : vd_q);
        vm_d = stall_m ? vm_q : ve_q;
        vw_d = flush_w ? 1'b0 : vm_q;

        cycle_cnt_d  = sat_inc(cycle_cnt_q, 1'b1);
        stall_cnt_d  = sat_inc(stall_cnt_q, stall_f);
        flush_cnt_d  = sat_inc(flush_cnt_q, flush_d);
        retire_cnt_d = sat_inc(retire_cnt_q, vw_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wcnt_q       <= '0;
            vd_q         <= 1'b0;
            ve_q         <= 1'b0;
            vm_q         <= 1'b0;
            vw_q         <= 1'b0;
            cycle_cnt_q  <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            vd_q         <= vd_d;
            ve_q         <= ve_d;
            vm_q         <= vm_d;
            vw_q         <= vw_d;
            cycle_cnt_q  <= cycle_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign hz.StallF_o    = stall_f;
    assign hz.StallD_o    = stall_d;
    assign hz.StallE_o    = stall_e;
    assign hz.StallM_o    = stall_m;
    assign hz.FlushD_o    = flush_d;
    assign hz.FlushE_o    = flush_e;
    assign hz.FlushW_o    = flush_w;
    assign hz.ForwardAE_o = fwd_a;
    assign hz.ForwardBE_o = fwd_b;
    assign hz.MemWait_o   = mw & ~rst;
    assign hz.CycleCnt_o  = cycle_cnt_q;
    assign hz.StallCnt_o  = stall_cnt_q;
    assign hz.FlushCnt_o  = flush_cnt_q;
    assign hz.RetireCnt_o = retire_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: two instances (LOAD_LAT=3/32-bit counters and
// LOAD_LAT=1/4-bit counters) driven identically and compared against a behavioural model.
module tb_pipeline_ctrl;

    localparam int RAW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [RAW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic           uses1d, uses2d, regwritee, loade, regwritem, loadm, regwritew, pcsrce;

    pipeline_ctrl_if #(.REG_ADDR_W(RAW), .CNT_WIDTH(32)) ifa ();
    pipeline_ctrl_if #(.REG_ADDR_W(RAW), .CNT_WIDTH(4))  ifb ();

    assign ifa.Rs1D_i = rs1d;       assign ifb.Rs1D_i = rs1d;
    assign ifa.Rs2D_i = rs2d;       assign ifb.Rs2D_i = rs2d;
    assign ifa.UsesRs1D_i = uses1d; assign ifb.UsesRs1D_i = uses1d;
    assign ifa.UsesRs2D_i = uses2d; assign ifb.UsesRs2D_i = uses2d;
    assign ifa.Rs1E_i = rs1e;       assign ifb.Rs1E_i = rs1e;
    assign ifa.Rs2E_i = rs2e;       assign ifb.Rs2E_i = rs2e;
    assign ifa.RdE_i = rde;         assign ifb.RdE_i = rde;
    assign ifa.RegWriteE_i = regwritee; assign ifb.RegWriteE_i = regwritee;
    assign ifa.LoadE_i = loade;     assign ifb.LoadE_i = loade;
    assign ifa.RdM_i = rdm;         assign ifb.RdM_i = rdm;
    assign ifa.RegWriteM_i = regwritem; assign ifb.RegWriteM_i = regwritem;
    assign ifa.LoadM_i = loadm;     assign ifb.LoadM_i = loadm;
    assign ifa.RdW_i = rdw;         assign ifb.RdW_i = rdw;
    assign ifa.RegWriteW_i = regwritew; assign ifb.RegWriteW_i = regwritew;
    assign ifa.PCSrcE_i = pcsrce;   assign ifb.PCSrcE_i = pcsrce;

    pipeline_ctrl #(.REG_ADDR_W(RAW), .LOAD_LAT(3), .CNT_WIDTH(32)) dut_a (
        .clk(clk), .rst(rst), .hz(ifa)
    );
    pipeline_ctrl #(.REG_ADDR_W(RAW), .LOAD_LAT(1), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst), .hz(ifb)
    );

    typedef struct packed {
        logic       sf, sd, se, sm, fd, fe, fw;
        logic [1:0] fa, fb;
        logic       mw;
    } ctl_t;

    int errors = 0;
    int checks = 0;

    // Reference model state, index 0 = dut_a, 1 = dut_b.
    int unsigned     lat  [2] = '{3, 1};
    longint unsigned cmax [2] = '{64'hFFFF_FFFF, 64'hF};
    int              busy_left [2];
    bit              vld [2][4];
    longint unsigned cyc [2], stl [2], fls [2], ret [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned sat(input longint unsigned c, input bit inc,
                                            input longint unsigned m);
        return (inc && c < m) ? c + 1 : c;
    endfunction

    function automatic logic [1:0] fwd(input logic [RAW-1:0] rs);
        if (regwritem && !loadm && rdm != 0 && rdm == rs) return 2'b10;
        if (regwritew && rdw != 0 && rdw == rs)           return 2'b01;
        return 2'b00;
    endfunction

    // A load episode lasts LOAD_LAT cycles: LOAD_LAT-1 waiting, then one release cycle.
    function automatic bit model_mw(input int k);
        if (busy_left[k] > 0) return busy_left[k] > 1;
        return loadm && lat[k] > 1;
    endfunction

    function automatic ctl_t expect_out(input int k);
        ctl_t r;
        bit   lu, mw;
        r = '0;
        if (rst) return r;
        mw = model_mw(k);
        lu = loade && regwritee && rde != 0 &&
             ((uses1d && rs1d == rde) || (uses2d && rs2d == rde));
        if (mw) begin
            r.sf = 1; r.sd = 1; r.se = 1; r.sm = 1; r.fw = 1;
        end else if (pcsrce) begin
            r.fd = 1; r.fe = 1;
        end else if (lu) begin
            r.sf = 1; r.sd = 1; r.fe = 1;
        end
        r.fa = fwd(rs1e);
        r.fb = fwd(rs2e);
        r.mw = mw;
        return r;
    endfunction

    function automatic ctl_t obs_a();
        ctl_t r;
        r = '{ifa.StallF_o, ifa.StallD_o, ifa.StallE_o, ifa.StallM_o, ifa.FlushD_o,
              ifa.FlushE_o, ifa.FlushW_o, ifa.ForwardAE_o, ifa.ForwardBE_o, ifa.MemWait_o};
        return r;
    endfunction

    function automatic ctl_t obs_b();
        ctl_t r;
        r = '{ifb.StallF_o, ifb.StallD_o, ifb.StallE_o, ifb.StallM_o, ifb.FlushD_o,
              ifb.FlushE_o, ifb.FlushW_o, ifb.ForwardAE_o, ifb.ForwardBE_o, ifb.MemWait_o};
        return r;
    endfunction

    task automatic model_reset_all();
        for (int k = 0; k < 2; k++) begin
            busy_left[k] = 0;
            for (int s = 0; s < 4; s++) vld[k][s] = 0;
            cyc[k] = 0; stl[k] = 0; fls[k] = 0; ret[k] = 0;
        end
    endtask

    task automatic model_update();
        ctl_t e;
        bit   nd, ne, nm, nw;
        if (rst) begin
            model_reset_all();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            e = expect_out(k);
            if (busy_left[k] > 0) busy_left[k]--;
            else if (loadm && lat[k] > 1) busy_left[k] = lat[k] - 1;
            nd = e.fd ? 0 : (e.sd ? vld[k][0] : 1);
            ne = e.fe ? 0 : (e.se ? vld[k][1] : vld[k][0]);
            nm = e.sm ? vld[k][2] : vld[k][1];
            nw = e.fw ? 0 : vld[k][2];
            ret[k] = sat(ret[k], vld[k][3], cmax[k]);
            cyc[k] = sat(cyc[k], 1, cmax[k]);
            stl[k] = sat(stl[k], e.sf, cmax[k]);
            fls[k] = sat(fls[k], e.fd, cmax[k]);
            vld[k][0] = nd; vld[k][1] = ne; vld[k][2] = nm; vld[k][3] = nw;
        end
    endtask

    task automatic check_all();
        check("ctl_a", 64'(obs_a()), 64'(expect_out(0)));
        check("ctl_b", 64'(obs_b()), 64'(expect_out(1)));
        check("cyc_a", 64'(ifa.CycleCnt_o), cyc[0]);
        check("stl_a", 64'(ifa.StallCnt_o), stl[0]);
        check("fls_a", 64'(ifa.FlushCnt_o), fls[0]);
        check("ret_a", 64'(ifa.RetireCnt_o), ret[0]);
        check("cyc_b", 64'(ifb.CycleCnt_o), cyc[1]);
        check("stl_b", 64'(ifb.StallCnt_o), stl[1]);
        check("fls_b", 64'(ifb.FlushCnt_o), fls[1]);
        check("ret_b", 64'(ifb.RetireCnt_o), ret[1]);
    endtask

    task automatic at_neg();
        @(negedge clk);
        check_all();
    endtask

    task automatic end_cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        rs1d = 0; rs2d = 0; rs1e = 0; rs2e = 0; rde = 0; rdm = 0; rdw = 0;
        uses1d = 0; uses2d = 0; regwritee = 0; loade = 0;
        regwritem = 0; loadm = 0; regwritew = 0; pcsrce = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        longint unsigned base;

        // Reset with hazards present on every input: outputs must still be quiet.
        idle();
        rst = 1;
        loadm = 1; regwritem = 1; rdm = 5; rs1e = 5; pcsrce = 1;
        model_reset_all();
        #3;
        check_all();
        check("rst_fwd", 64'(ifa.ForwardAE_o), 64'd0);
        check("rst_mw", 64'(ifa.MemWait_o), 64'd0);
        end_cycle();
        idle();
        rst = 0;

        // Forwarding: M beats W, rd=x0 never forwards.
        regwritem = 1; rdm = 5; regwritew = 1; rdw = 5; rs1e = 5;
        at_neg();
        check("fwd_m", 64'(ifa.ForwardAE_o), 64'd2);
        end_cycle();
        rdm = 0;
        at_neg();
        check("fwd_w", 64'(ifa.ForwardAE_o), 64'd1);
        end_cycle();
        rs2e = 0; rdw = 0;
        at_neg();
        check("fwd_b_none", 64'(ifa.ForwardBE_o), 64'd0);
        end_cycle();

        // Load-use on rs2.
        idle();
        loade = 1; regwritee = 1; rde = 7; rs2d = 7; uses2d = 1;
        at_neg();
        check("lu_stall", 64'({ifa.StallF_o, ifa.StallD_o, ifa.FlushE_o}), 64'b111);
        base = stl[0];
        end_cycle();
        uses2d = 0;
        at_neg();
        check("lu_cnt", 64'(ifa.StallCnt_o), base + 1);
        check("lu_off", 64'({ifa.StallF_o, ifa.StallD_o, ifa.FlushE_o}), 64'b000);
        end_cycle();

        // Redirect overrides load-use.
        uses2d = 1; pcsrce = 1;
        at_neg();
        check("br_flush", 64'({ifa.FlushD_o, ifa.FlushE_o, ifa.StallF_o, ifa.StallD_o}), 64'b1100);
        base = fls[0];
        end_cycle();
        idle();
        at_neg();
        check("br_cnt", 64'(ifa.FlushCnt_o), base + 1);
        end_cycle();

        // Multi-cycle load wait on dut_a (LOAD_LAT=3).
        loadm = 1; regwritem = 1; rdm = 3;
        at_neg();
        check("mw1", 64'({ifa.MemWait_o, ifa.StallM_o, ifa.StallE_o, ifa.FlushW_o}), 64'b1111);
        end_cycle();
        pcsrce = 1;
        at_neg();
        check("mw2", 64'({ifa.MemWait_o, ifa.StallF_o}), 64'b11);
        check("mw2_flushd", 64'(ifa.FlushD_o), 64'd0);
        end_cycle();
        pcsrce = 0;
        at_neg();
        check("mw3_done", 64'({ifa.StallF_o, ifa.StallD_o, ifa.StallE_o, ifa.StallM_o,
                                ifa.FlushW_o, ifa.MemWait_o}), 64'd0);
        end_cycle();
        at_neg();
        check("mw_next_load", 64'(ifa.MemWait_o), 64'd1);
        end_cycle();

        // Asynchronous reset while in WAIT.
        rst = 1;
        model_reset_all();
        #1;
        check_all();
        check("rst_mid_mw", 64'({ifa.MemWait_o, ifa.StallF_o, ifa.FlushW_o}), 64'd0);
        check("rst_mid_cyc", 64'(ifa.CycleCnt_o), 64'd0);
        end_cycle();
        idle();
        rst = 0;
        at_neg();
        check("post_rst_cyc", 64'(ifa.CycleCnt_o), 64'd0);
        check("post_rst_mw", 64'(ifa.MemWait_o), 64'd0);
        end_cycle();

        // 20 idle edges since release: 4-bit counters saturate.
        for (int n = 1; n < 20; n++) begin
            at_neg();
            end_cycle();
        end
        at_neg();
        check("sat_cyc_b", 64'(ifb.CycleCnt_o), 64'd15);
        check("sat_ret_b", 64'(ifb.RetireCnt_o), 64'd15);
        check("sat_stl_b", 64'(ifb.StallCnt_o), 64'd0);
        check("cyc_a_20", 64'(ifa.CycleCnt_o), 64'd20);
        check("ret_a_16", 64'(ifa.RetireCnt_o), 64'd16);
        end_cycle();

        // Randomised traffic with a small register window to force collisions.
        for (int n = 0; n < 400; n++) begin
            rs1d = RAW'($urandom_range(0, 3)); rs2d = RAW'($urandom_range(0, 3));
            rs1e = RAW'($urandom_range(0, 3)); rs2e = RAW'($urandom_range(0, 3));
            rde  = RAW'($urandom_range(0, 3)); rdm  = RAW'($urandom_range(0, 3));
            rdw  = RAW'($urandom_range(0, 3));
            uses1d    = 1'($urandom_range(0, 1));
            uses2d    = 1'($urandom_range(0, 1));
            regwritee = 1'($urandom_range(0, 1));
            loade     = 1'($urandom_range(0, 1));
            regwritem = 1'($urandom_range(0, 1));
            regwritew = 1'($urandom_range(0, 1));
            loadm     = ($urandom_range(0, 5) == 0);
            pcsrce    = ($urandom_range(0, 7) == 0);
            at_neg();
            end_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
